// File: rtl/ram_dp_sr_sw_be.sv
// Simple dual-port RAM (one write, one read port) with byte enables, a write/read-protected
// upper region, error counting and a 1- or 2-cycle read pipeline. Define RAM_WR_BYPASS_EN to forward
// same-cycle write bytes to a colliding read; otherwise collisions read the pre-write word.
module ram_dp_sr_sw_be #(
  parameter int                  DATA_WIDTH    = 64,
  parameter int                  ADDR_WIDTH    = 8,
  parameter logic [ADDR_WIDTH:0] PROT_BASE     = 9'd240,
  parameter int                  READ_LATENCY  = 1,
  parameter int                  ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_cs,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH/8-1:0]  wr_be,
  input  logic                     rd_cs,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic                     wr_err,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int N_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_prot, rd_prot, wr_ok, rd_viol, wr_viol;

  assign wr_prot = {1'b0, wr_addr} >= PROT_BASE;
  assign rd_prot = {1'b0, rd_addr} >= PROT_BASE;
  assign wr_ok   = wr_cs && !wr_prot;
  assign wr_viol = wr_cs && wr_prot;
  assign rd_viol = rd_cs && rd_prot;

  // NOTE: the storage array has no reset; clearing it would prevent RAM inference and is not needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Word seen by the read port this cycle: pre-write contents, optionally merged with write bytes.
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    // NOTE: default first so every path assigns rd_word and no latch is inferred.
    rd_word = mem[rd_addr];
`ifdef RAM_WR_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr)) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
`endif
  end

  logic                  s1_valid, s1_err;
  logic [DATA_WIDTH-1:0] s1_data;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_cs;
      s1_err   <= rd_viol;
      if (rd_cs) s1_data <= rd_prot ? '0 : rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid, s2_err;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_err   = s2_err;
      assign rd_data  = s2_data;
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_err   = s1_err;
      assign rd_data  = s1_data;
    end
  endgenerate

  // Error counter: adds 0..2 events per cycle, saturates, and a clear keeps this cycle's events.
  logic [1:0]             ev_cnt;
  logic [ERR_CNT_WIDTH:0] cnt_base, cnt_sum;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_nxt;

  always_comb begin
    ev_cnt      = {1'b0, wr_viol} + {1'b0, rd_viol};
    cnt_base    = err_clr ? '0 : {1'b0, err_cnt};
    cnt_sum     = cnt_base + (ERR_CNT_WIDTH+1)'(ev_cnt);
    err_cnt_nxt = cnt_sum[ERR_CNT_WIDTH] ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err  <= 1'b0;
      err_cnt <= '0;
    end else begin
      wr_err  <= wr_viol;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// Directed bench for ram_dp_sr_sw_be: one instance at READ_LATENCY=1 and one at 2 share stimulus.
module tb_ram_dp_sr_sw_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_cs, rd_cs, err_clr;
  logic [7:0]  wr_addr, rd_addr, wr_be;
  logic [63:0] wr_data;

  logic [63:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2, rd_err1, rd_err2, wr_err1, wr_err2;
  logic [7:0]  err_cnt1, err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_sr_sw_be #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_err(rd_err1),
    .wr_err(wr_err1), .err_clr(err_clr), .err_cnt(err_cnt1));

  ram_dp_sr_sw_be #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_err(rd_err2),
    .wr_err(wr_err2), .err_clr(err_clr), .err_cnt(err_cnt2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_cs = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_cs = 1'b0;
  endtask

  // Single read; checks latency-1 output after one edge and latency-2 output after two.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [63:0] d, input logic e);
    rd_cs = 1'b1; rd_addr = a;
    tick();
    rd_cs = 1'b0;
    check({tag, " v1"}, 64'(rd_valid1), 64'd1);
    check({tag, " d1"}, rd_data1, d);
    check({tag, " e1"}, 64'(rd_err1), 64'(e));
    check({tag, " v2 early"}, 64'(rd_valid2), 64'd0);
    tick();
    check({tag, " v1 drop"}, 64'(rd_valid1), 64'd0);
    check({tag, " d1 hold"}, rd_data1, d);
    check({tag, " e1 drop"}, 64'(rd_err1), 64'd0);
    check({tag, " v2"}, 64'(rd_valid2), 64'd1);
    check({tag, " d2"}, rd_data2, d);
    check({tag, " e2"}, 64'(rd_err2), 64'(e));
    tick();
    check({tag, " v2 drop"}, 64'(rd_valid2), 64'd0);
  endtask

  logic [63:0] exp_coll;

  initial begin
    rst_n = 1'b0; wr_cs = 1'b0; rd_cs = 1'b0; err_clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    tick();
    check("rst rd_valid1", 64'(rd_valid1), 64'd0);
    check("rst rd_valid2", 64'(rd_valid2), 64'd0);
    check("rst rd_data1", rd_data1, 64'd0);
    check("rst wr_err", 64'(wr_err1), 64'd0);
    check("rst err_cnt", 64'(err_cnt1), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full write then read back
    do_write(8'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
    check("wr ok no err", 64'(wr_err1), 64'd0);
    do_read("rd10", 8'h10, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Partial byte-enable overwrite
    do_write(8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_read("rd10 be", 8'h10, 64'h0123_4567_FFFF_FFFF, 1'b0);

    // Boundary: last unprotected address stores normally
    do_write(8'hEF, 64'h5555_0000_1111_2222, 8'hFF);
    check("wr EF no err", 64'(wr_err1), 64'd0);
    do_read("rdEF", 8'hEF, 64'h5555_0000_1111_2222, 1'b0);

    // Protected write: wr_err pulse and count
    do_write(8'hF3, 64'h1234, 8'hFF);
    check("wrF3 wr_err1", 64'(wr_err1), 64'd1);
    check("wrF3 wr_err2", 64'(wr_err2), 64'd1);
    check("wrF3 cnt", 64'(err_cnt1), 64'd1);
    tick();
    check("wrF3 pulse end", 64'(wr_err1), 64'd0);
    do_read("rdF3", 8'hF3, 64'd0, 1'b1);
    check("rdF3 cnt1", 64'(err_cnt1), 64'd2);
    check("rdF3 cnt2", 64'(err_cnt2), 64'd2);

    // First protected address
    do_write(8'hF0, 64'h77, 8'hFF);
    check("wrF0 wr_err", 64'(wr_err1), 64'd1);
    check("wrF0 cnt", 64'(err_cnt1), 64'd3);

    // Same-cycle same-address collision
`ifdef RAM_WR_BYPASS_EN
    exp_coll = 64'hAAAA_AAAA_AAAA_AAAA;
`else
    exp_coll = 64'h0123_4567_FFFF_FFFF;
`endif
    wr_cs = 1'b1; wr_addr = 8'h10; wr_data = 64'hAAAA_AAAA_AAAA_AAAA; wr_be = 8'hFF;
    rd_cs = 1'b1; rd_addr = 8'h10;
    tick();
    wr_cs = 1'b0; rd_cs = 1'b0;
    check("coll d1", rd_data1, exp_coll);
    tick();
    check("coll d2", rd_data2, exp_coll);
    tick();
    do_read("rd10 after coll", 8'h10, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);

    // Independent ports, plus a wr_be=0 no-op write
    wr_cs = 1'b1; wr_addr = 8'h20; wr_data = 64'hDEAD_BEEF_CAFE_F00D; wr_be = 8'hFF;
    rd_cs = 1'b1; rd_addr = 8'h10;
    tick();
    wr_cs = 1'b0; rd_cs = 1'b0;
    check("indep d1", rd_data1, 64'hAAAA_AAAA_AAAA_AAAA);
    tick(); tick();
    do_write(8'h20, 64'd0, 8'h00);
    do_read("rd20", 8'h20, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

    // Saturation of err_cnt and clear with a coincident violation
    wr_cs = 1'b1; wr_addr = 8'hFF; wr_be = 8'hFF;
    for (int i = 0; i < 300; i++) tick();
    check("sat cnt1", 64'(err_cnt1), 64'd255);
    check("sat cnt2", 64'(err_cnt2), 64'd255);
    err_clr = 1'b1;
    tick();
    check("clr+ev cnt", 64'(err_cnt1), 64'd1);
    wr_cs = 1'b0;
    tick();
    check("clr only cnt", 64'(err_cnt1), 64'd0);
    err_clr = 1'b0;
    wr_cs = 1'b1; wr_addr = 8'hF8; rd_cs = 1'b1; rd_addr = 8'hFA;
    tick();
    wr_cs = 1'b0; rd_cs = 1'b0;
    check("dual ev cnt", 64'(err_cnt1), 64'd2);
    tick(); tick();

    // Reset in the middle of a read burst
    for (int i = 0; i < 8; i++) do_write(8'(i), 64'(i + 1), 8'hFF);
    for (int i = 0; i < 3; i++) begin
      rd_cs = 1'b1; rd_addr = 8'(i);
      tick();
    end
    check("burst d1", rd_data1, 64'd3);
    check("burst v2", 64'(rd_valid2), 64'd1);
    check("burst d2", rd_data2, 64'd2);
    rst_n = 1'b0;
    #1;
    check("arst v1", 64'(rd_valid1), 64'd0);
    check("arst v2", 64'(rd_valid2), 64'd0);
    check("arst d1", rd_data1, 64'd0);
    check("arst d2", rd_data2, 64'd0);
    check("arst cnt", 64'(err_cnt2), 64'd0);
    for (int i = 3; i < 5; i++) begin
      rd_addr = 8'(i);
      tick();
    end
    rd_cs = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post rst v1", 64'(rd_valid1), 64'd0);
      check("post rst v2", 64'(rd_valid2), 64'd0);
    end
    check("post rst d2", rd_data2, 64'd0);
    do_read("rd02 after rst", 8'h02, 64'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
